// File: rtl/apb_req_arbiter_if.sv
// APB bus bundle between the requester arbiter (master) and an APB slave.
//   P_addr/P_write/P_wdata : transfer address, direction and write data
//   P_selx/P_enable        : SETUP/ACCESS phase controls
//   P_ready/P_slverr       : slave completion and error
//   P_rdata                : slave read data
interface apb_req_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0] P_addr;
  logic              P_selx;
  logic              P_enable;
  logic              P_write;
  logic [DATA_W-1:0] P_wdata;
  logic              P_ready;
  logic              P_slverr;
  logic [DATA_W-1:0] P_rdata;

  modport master (
    output P_addr, P_selx, P_enable, P_write, P_wdata,
    input  P_ready, P_slverr, P_rdata
  );

  modport slave (
    input  P_addr, P_selx, P_enable, P_write, P_wdata,
    output P_ready, P_slverr, P_rdata
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-port requester front end and APB master sequencer.
// Requests from port 0/1 are arbitrated round-robin in IDLE, then driven through
// the APB SETUP and ACCESS phases. Completion returns a one-cycle rspN_valid pulse
// with read data (0 for writes) and the slave error flag to the owning port.
// Ports:
//   P_clk, P_rst_n       : clock, asynchronous active-low reset
//   reqN_valid/write/addr/wdata : request from port N, reqN_ready accepts it
//   rspN_valid/rdata/err : response strobe and payload for port N
//   apb (master modport) : APB bus
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC
// cycles with P_ready low, reporting rspN_err=1 and rspN_rdata=0.
module apb_req_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              P_clk,
  input  logic              P_rst_n,

  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,

  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,

  apb_req_arbiter_if.master apb
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q;
  logic              last_grant_q;  // port granted most recently
  logic              owner_q;       // port owning the in-flight transfer
  logic              gnt0;
  logic              gnt1;
  logic              timeout;
  logic              done;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [CntW-1:0] wait_q;
  // This edge would close the TIMEOUT_CYC-th wait cycle.
  assign timeout = (state_q == StAccess) && !apb.P_ready &&
                   (wait_q == CntW'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  // On a tie the port not granted last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle) begin
      gnt0 = req0_valid && (!req1_valid || last_grant_q);
      gnt1 = req1_valid && (!req0_valid || !last_grant_q);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Ready wins over a coincident timeout.
  always_comb begin
    done        = (state_q == StAccess) && (apb.P_ready || timeout);
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b1;
    if (apb.P_ready) begin
      rsp_err_d = apb.P_slverr;
      if (!apb.P_write) begin
        rsp_rdata_d = apb.P_rdata;
      end
    end
  end

  always_ff @(posedge P_clk or negedge P_rst_n) begin
    if (!P_rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      apb.P_addr   <= '0;
      apb.P_selx   <= 1'b0;
      apb.P_enable <= 1'b0;
      apb.P_write  <= 1'b0;
      apb.P_wdata  <= '0;
      rsp0_valid   <= 1'b0;
      rsp0_rdata   <= '0;
      rsp0_err     <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_rdata   <= '0;
      rsp1_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_q       <= '0;
`endif
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (gnt0 || gnt1) begin
            owner_q      <= gnt1;
            last_grant_q <= gnt1;
            apb.P_addr   <= gnt1 ? req1_addr  : req0_addr;
            apb.P_write  <= gnt1 ? req1_write : req0_write;
            apb.P_wdata  <= gnt1 ? req1_wdata : req0_wdata;
            apb.P_selx   <= 1'b1;
            state_q      <= StSetup;
          end
        end
        StSetup: begin
          apb.P_enable <= 1'b1;
          state_q      <= StAccess;
`ifdef APB_TIMEOUT_EN
          wait_q       <= '0;
`endif
        end
        StAccess: begin
          if (done) begin
            if (owner_q) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= rsp_rdata_d;
              rsp1_err   <= rsp_err_d;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= rsp_rdata_d;
              rsp0_err   <= rsp_err_d;
            end
            apb.P_selx   <= 1'b0;
            apb.P_enable <= 1'b0;
            state_q      <= StIdle;
          end
`ifdef APB_TIMEOUT_EN
          else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
  logic [31:0] req1_addr, req1_wdata, rsp1_rdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wait_target = 0;
  bit          err_cfg = 1'b0;
  logic [31:0] mem [16];

  apb_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) apb ();

  apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .P_clk      (clk),
    .P_rst_n    (rst_n),
    .req0_valid (req0_valid),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp0_err   (rsp0_err),
    .req1_valid (req1_valid),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .rsp1_err   (rsp1_err),
    .apb        (apb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // APB slave model: wait_target wait cycles, then ready with err_cfg.
  initial begin
    int wcnt;
    wcnt = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    apb.P_ready  = 1'b0;
    apb.P_slverr = 1'b0;
    apb.P_rdata  = '0;
    forever begin
      @(negedge clk);
      if (apb.P_selx && apb.P_enable) begin
        if (wcnt < wait_target) begin
          apb.P_ready = 1'b0;
          wcnt++;
        end else begin
          apb.P_ready  = 1'b1;
          apb.P_slverr = err_cfg;
          if (apb.P_write) begin
            apb.P_rdata = 32'hdead_beef;
            mem[apb.P_addr[5:2]] = apb.P_wdata;
          end else begin
            apb.P_rdata = mem[apb.P_addr[5:2]];
          end
        end
      end else begin
        apb.P_ready  = 1'b0;
        apb.P_slverr = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transfer on a port; en_exp is the number of cycles P_enable stays high.
  task automatic do_xfer(input int port, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata_exp,
                         input bit err_exp, input int en_exp);
    int   en_cnt;
    bit   got;
    bit   other_rsp;
    logic my_rdy, other_rdy;
    @(negedge clk);
    if (port == 0) begin
      req0_write = wr; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1;
    end else begin
      req1_write = wr; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1;
    end
    #1;
    my_rdy    = (port == 0) ? req0_ready : req1_ready;
    other_rdy = (port == 0) ? req1_ready : req0_ready;
    check_eq($sformatf("p%0d ready", port), my_rdy, 1'b1);
    check_eq($sformatf("p%0d other ready", port), other_rdy, 1'b0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("setup selx", apb.P_selx, 1'b1);
    check_eq("setup enable", apb.P_enable, 1'b0);
    check_eq("setup addr", apb.P_addr, addr);
    check_eq("setup write", apb.P_write, wr);
    en_cnt    = 0;
    got       = 1'b0;
    other_rsp = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if ((port == 0) ? rsp1_valid : rsp0_valid) other_rsp = 1'b1;
      if ((port == 0) ? rsp0_valid : rsp1_valid) got = 1'b1;
      else if (apb.P_enable) en_cnt++;
    end
    check_eq($sformatf("p%0d rsp seen", port), got, 1'b1);
    check_eq($sformatf("p%0d enable cycles", port), en_cnt, en_exp);
    check_eq($sformatf("p%0d rdata", port), (port == 0) ? rsp0_rdata : rsp1_rdata, rdata_exp);
    check_eq($sformatf("p%0d err", port), (port == 0) ? rsp0_err : rsp1_err, err_exp);
    check_eq($sformatf("p%0d other rsp", port), other_rsp, 1'b0);
    check_eq("rsp cycle selx", apb.P_selx, 1'b0);
  endtask

  initial begin
    int   grants [8];
    int   n_grants, cnt0, cnt1, nrsp0, nrsp1;
    bit   both_rdy, en_seen, late_rsp;
    logic r0, r1;

    rst_n = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst selx", apb.P_selx, 1'b0);
    check_eq("rst enable", apb.P_enable, 1'b0);
    check_eq("rst addr", apb.P_addr, 32'h0);
    check_eq("rst write", apb.P_write, 1'b0);
    check_eq("rst wdata", apb.P_wdata, 32'h0);
    check_eq("rst ready", {req0_ready, req1_ready}, 2'b00);
    check_eq("rst rsp valid", {rsp0_valid, rsp1_valid}, 2'b00);
    check_eq("rst rsp data", {rsp0_rdata, rsp1_rdata}, 64'h0);
    check_eq("rst rsp err", {rsp0_err, rsp1_err}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write, readback, write on port 1, wait states with slave error.
    do_xfer(0, 1'b1, 32'h4, 32'h7, 32'h0, 1'b0, 1);
    do_xfer(1, 1'b0, 32'h4, 32'h0, 32'h7, 1'b0, 1);
    do_xfer(1, 1'b1, 32'h8, 32'h55, 32'h0, 1'b0, 1);
    err_cfg = 1'b1; wait_target = 4;
    do_xfer(0, 1'b0, 32'h8, 32'h0, 32'h55, 1'b1, 5);
    err_cfg = 1'b0; wait_target = 0;

    // Simultaneous requests from reset: expect 0, 1, 0, 1.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst2 selx", apb.P_selx, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req0_write = 1'b1; req0_addr = 32'h10; req0_wdata = 32'ha0; req0_valid = 1'b1;
    req1_write = 1'b1; req1_addr = 32'h20; req1_wdata = 32'hb0; req1_valid = 1'b1;
    n_grants = 0; cnt0 = 0; cnt1 = 0; nrsp0 = 0; nrsp1 = 0; both_rdy = 1'b0;
    for (int c = 0; c < 40 && n_grants < 4; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      r0 = req0_ready;
      r1 = req1_ready;
      if (r0 && r1) both_rdy = 1'b1;
      if (rsp0_valid) nrsp0++;
      if (rsp1_valid) nrsp1++;
      if (r0 && n_grants < 8) begin grants[n_grants] = 0; n_grants++; end
      if (r1 && n_grants < 8) begin grants[n_grants] = 1; n_grants++; end
      @(posedge clk);
      #1;
      if (r0) begin
        cnt0++;
        if (cnt0 == 2) req0_valid = 1'b0;
        else req0_addr = req0_addr + 32'h4;
      end
      if (r1) begin
        cnt1++;
        if (cnt1 == 2) req1_valid = 1'b0;
        else req1_addr = req1_addr + 32'h4;
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp0_valid) nrsp0++;
      if (rsp1_valid) nrsp1++;
    end
    check_eq("tie grant count", n_grants, 4);
    check_eq("tie both ready", both_rdy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("tie grant %0d", i), grants[i], i % 2);
    end
    check_eq("tie rsp0 count", nrsp0, 2);
    check_eq("tie rsp1 count", nrsp1, 2);
    check_eq("tie mem 0x14", mem[5], 32'ha0);
    check_eq("tie mem 0x24", mem[9], 32'hb0);

    // Reset during ACCESS drops the transfer asynchronously.
    wait_target = 10;
    @(negedge clk);
    req0_write = 1'b0; req0_addr = 32'h4; req0_valid = 1'b1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    en_seen = 1'b0;
    for (int c = 0; c < 6 && !en_seen; c++) begin
      @(negedge clk);
      if (apb.P_enable) en_seen = 1'b1;
    end
    check_eq("mid access reached", en_seen, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid rst selx", apb.P_selx, 1'b0);
    check_eq("mid rst enable", apb.P_enable, 1'b0);
    check_eq("mid rst addr", apb.P_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_target = 0;
    late_rsp = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) late_rsp = 1'b1;
    end
    check_eq("mid rst no rsp", late_rsp, 1'b0);
    check_eq("mid rst idle selx", apb.P_selx, 1'b0);

    // First tie-free request after reset on port 1.
    do_xfer(1, 1'b0, 32'h4, 32'h0, 32'h7, 1'b0, 1);

`ifdef APB_TIMEOUT_EN
    wait_target = 100;
    do_xfer(1, 1'b0, 32'h4, 32'h0, 32'h0, 1'b1, 16);
    wait_target = 0;
    do_xfer(0, 1'b0, 32'h4, 32'h0, 32'h7, 1'b0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
